// File: rtl/hb_mac_scheduler_if.sv
// Bus bundle for hb_mac_scheduler: frame input, coefficient port, filtered
// output and status.
interface hb_mac_scheduler_if #(
  parameter int NCH = 20,
  parameter int DW  = 17,
  parameter int CW  = 16,
  parameter int OW  = 18
);
  logic                  x_valid;
  logic [NCH*DW-1:0]     x_in;
  logic [3:0]            coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic signed [OW-1:0]  y_out;
  logic [4:0]            y_ch;
  logic                  y_valid;
  logic                  frame_done;
  logic                  busy;
  logic                  overrun;

  modport master (
    output x_valid, x_in, coef_data,
    input  coef_addr, y_out, y_ch, y_valid, frame_done, busy, overrun
  );

  modport slave (
    input  x_valid, x_in, coef_data,
    output coef_addr, y_out, y_ch, y_valid, frame_done, busy, overrun
  );
endinterface

// File: rtl/hb_mac_scheduler.sv
// Halfband decimator back end: NCH channels time-share one MAC, each channel
// filtered over an NTAP-deep circular history with a shared write pointer.
module hb_mac_scheduler #(
  parameter int NCH  = 20,
  parameter int NTAP = 11,
  parameter int DW   = 17,
  parameter int CW   = 16,
  parameter int OW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  hb_mac_scheduler_if.slave  bus
);

  localparam int PW  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = DW + CW + 4;
  localparam int PDW = DW + CW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [PW:0]          NTAP_W = (PW+1)'(NTAP);
  localparam logic signed [AW-1:0] HALF   = AW'(longint'(1) << (CW-2));
  localparam logic signed [AW-1:0] Y_MAX  = AW'((longint'(1) << (OW-1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN  = ~Y_MAX;

  logic [1:0]              state;
  logic [CHW-1:0]          ch;
  logic [PW-1:0]           k;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           last_ptr;
  logic [PW-1:0]           rd_idx;
  logic signed [DW-1:0]    hist [NCH][NTAP];
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_next;
  logic signed [AW-1:0]    rnd;
  logic signed [PDW-1:0]   prod;
  logic signed [OW-1:0]    y_sat;
  logic                    accept;
  logic                    last_tap;
  logic                    last_ch;

  assign accept        = bus.x_valid && !bus.busy;
  assign last_tap      = (k == PW'(NTAP-1));
  assign last_ch       = (ch == CHW'(NCH-1));
  assign last_ptr      = (wr_ptr == '0) ? PW'(NTAP-1) : wr_ptr - PW'(1);
  assign bus.coef_addr = (state == ST_MAC) ? 4'(k) : 4'd0;

  // Tap k reads the sample written k frames before the newest one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_idx = last_ptr - k;
    if (k > last_ptr) rd_idx = PW'({1'b0, last_ptr} + NTAP_W - {1'b0, k});
  end

  always_comb begin
    prod     = PDW'(bus.coef_data) * PDW'(hist[ch][rd_idx]);
    acc_next = acc + AW'(prod);
    rnd      = (acc_next + HALF) >>> (CW-1);
    y_sat    = rnd[OW-1:0];
    if (rnd > Y_MAX)      y_sat = Y_MAX[OW-1:0];
    else if (rnd < Y_MIN) y_sat = Y_MIN[OW-1:0];
  end

  // NOTE: the history is cleared by reset because stale samples would leak into
  // the first NTAP-1 outputs after reset; this makes it flops, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAP; t++)
          hist[c][t] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NCH; c++)
        hist[c][wr_ptr] <= bus.x_in[c*DW +: DW];
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      ch             <= '0;
      k              <= '0;
      wr_ptr         <= '0;
      acc            <= '0;
      bus.y_out      <= '0;
      bus.y_ch       <= '0;
      bus.y_valid    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.y_valid    <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.x_valid && bus.busy) bus.overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_ptr   <= (wr_ptr == PW'(NTAP-1)) ? '0 : wr_ptr + PW'(1);
            ch       <= '0;
            bus.busy <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          acc   <= '0;
          k     <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          acc <= acc_next;
          k   <= last_tap ? '0 : k + PW'(1);
          // Result registers on the final tap so y_valid is visible during OUT,
          // (c+1)*(NTAP+2) cycles after the frame was accepted.
          if (last_tap) begin
            bus.y_out      <= y_sat;
            bus.y_ch       <= 5'(ch);
            bus.y_valid    <= 1'b1;
            bus.frame_done <= last_ch;
            state          <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (last_ch) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            ch    <= ch + CHW'(1);
            state <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_mac_scheduler.sv
// Randomized self-checking bench for hb_mac_scheduler against a frame-history
// convolution model, with impulse, saturation, overrun and mid-frame reset cases.
module tb_hb_mac_scheduler;

  localparam int NCH   = 20;
  localparam int NTAP  = 11;
  localparam int DW    = 17;
  localparam int CW    = 16;
  localparam int OW    = 18;
  localparam int SLOT  = NTAP + 2;
  localparam int FRAME = NCH * SLOT;
  localparam longint YMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint YMIN = -(longint'(1) << (OW-1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hb_mac_scheduler_if #(.NCH(NCH), .DW(DW), .CW(CW), .OW(OW)) bus ();

  hb_mac_scheduler #(.NCH(NCH), .NTAP(NTAP), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int coef [16];
  assign bus.coef_data = CW'(coef[bus.coef_addr]);

  int      n_checks = 0;
  int      n_fail   = 0;
  bit      exp_ovr  = 1'b0;
  longint  hold_y   = 0;
  int      hold_ch  = 0;
  logic [NCH*DW-1:0] hist_q [$];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // kind 0: random, 1: ramp from val, 2: all channels val, 3: val on channel 0 only
  function automatic logic [NCH*DW-1:0] make_frame(input int kind, input int val);
    logic [NCH*DW-1:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++) begin
      case (kind)
        0:       f[c*DW +: DW] = DW'($urandom);
        1:       f[c*DW +: DW] = DW'(val + c * 37);
        2:       f[c*DW +: DW] = DW'(val);
        default: f[c*DW +: DW] = (c == 0) ? DW'(val) : '0;
      endcase
    end
    return f;
  endfunction

  // y = sat(round(sum_k coef[k] * x[n-k])), frames before reset count as zero.
  function automatic longint model_y(input int c);
    longint acc;
    int     n;
    acc = 0;
    n   = hist_q.size();
    for (int kk = 0; kk < NTAP; kk++) begin
      if (n - 1 - kk >= 0) begin
        logic [NCH*DW-1:0]    f;
        logic signed [DW-1:0] s;
        f = hist_q[n-1-kk];
        s = f[c*DW +: DW];
        acc += longint'(coef[kk]) * longint'(s);
      end
    end
    acc = (acc + (longint'(1) << (CW-2))) >>> (CW-1);
    if (acc > YMAX) acc = YMAX;
    if (acc < YMIN) acc = YMIN;
    return acc;
  endfunction

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_y_out"},      bus.y_out,      0);
    check({pfx, "_y_ch"},       bus.y_ch,       0);
    check({pfx, "_y_valid"},    bus.y_valid,    0);
    check({pfx, "_frame_done"}, bus.frame_done, 0);
    check({pfx, "_busy"},       bus.busy,       0);
    check({pfx, "_overrun"},    bus.overrun,    0);
    check({pfx, "_coef_addr"},  bus.coef_addr,  0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.x_valid = 1'b0;
      bus.x_in    = make_frame(0, 0);
      @(negedge clk);
      check("idle_y_valid",    bus.y_valid,    0);
      check("idle_busy",       bus.busy,       0);
      check("idle_frame_done", bus.frame_done, 0);
      check("idle_y_out_hold", bus.y_out,      hold_y);
      check("idle_y_ch_hold",  bus.y_ch,       hold_ch);
      check("idle_overrun",    bus.overrun,    exp_ovr);
    end
  endtask

  // Presents one frame in cycle 0 and checks every cycle 1..FRAME against the
  // schedule; inject_at drops an extra x_valid, reset_at pulls reset mid-frame.
  task automatic run_frame(input logic [NCH*DW-1:0] data, input int inject_at,
                           input int reset_at, output longint y0);
    longint exp_y [NCH];
    bit     exp_v;
    int     ph;
    int     c;
    y0 = 0;
    @(posedge clk); #1;
    bus.x_valid = 1'b1;
    bus.x_in    = data;
    hist_q.push_back(data);
    if (hist_q.size() > NTAP) void'(hist_q.pop_front());
    for (int i = 0; i < NCH; i++) exp_y[i] = model_y(i);

    for (int t = 1; t <= FRAME; t++) begin
      @(posedge clk); #1;
      bus.x_valid = (t == inject_at);
      bus.x_in    = make_frame(0, 0);
      if (t == reset_at) begin
        bus.x_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_zero_outputs("midrst");
        hist_q.delete();
        exp_ovr = 1'b0;
        hold_y  = 0;
        hold_ch = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        break;
      end
      @(negedge clk);
      exp_v = (t % SLOT == 0);
      ph    = (t - 1) % SLOT;
      check("y_valid",    bus.y_valid,    exp_v);
      check("busy",       bus.busy,       1);
      check("frame_done", bus.frame_done, t == FRAME);
      check("overrun",    bus.overrun,    exp_ovr);
      check("coef_addr",  bus.coef_addr,  (ph >= 1 && ph <= NTAP) ? ph - 1 : 0);
      if (exp_v) begin
        c       = t / SLOT - 1;
        hold_y  = exp_y[c];
        hold_ch = c;
        if (c == 0) y0 = bus.y_out;
      end
      check("y_out", bus.y_out, hold_y);
      check("y_ch",  bus.y_ch,  hold_ch);
      if (t == inject_at) exp_ovr = 1'b1;
    end
  endtask

  initial begin
    int     imp [4];
    longint y0;

    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    for (int i = 0; i < 16; i++) coef[i] = 0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;
    idle(3);

    // Impulse through a 3-tap kernel placed in the first three taps.
    coef[0] = 16384; coef[1] = 32767; coef[2] = 16384;
    imp = '{500, 1000, 500, 0};
    for (int j = 0; j < 4; j++) begin
      run_frame(make_frame(j == 0 ? 3 : 2, j == 0 ? 1000 : 0), 0, 0, y0);
      check("impulse_ch0", y0, imp[j]);
    end
    idle(4);

    // Random signed coefficients, ramp input across several wr_ptr wraps.
    for (int i = 0; i < NTAP; i++) coef[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int j = 0; j < 2 * NTAP + 1; j++)
      run_frame(make_frame(1, j * 1500 - 17000), 0, 0, y0);

    // Random data; extra x_valid mid-frame and on the OUT cycle of the last channel.
    run_frame(make_frame(0, 0), 50, 0, y0);
    run_frame(make_frame(0, 0), FRAME, 0, y0);
    run_frame(make_frame(0, 0), $urandom_range(1, FRAME), 0, y0);
    idle(5);

    // Saturation at both rails.
    for (int i = 0; i < NTAP; i++) coef[i] = 32767;
    for (int j = 0; j < NTAP; j++) run_frame(make_frame(2, 65535), 0, 0, y0);
    check("sat_pos", y0, 131071);
    for (int j = 0; j < NTAP; j++) run_frame(make_frame(2, -65536), 0, 0, y0);
    check("sat_neg", y0, -131072);

    // Reset mid-frame, then a fresh impulse.
    for (int i = 0; i < 16; i++) coef[i] = 0;
    coef[0] = 16384; coef[1] = 32767; coef[2] = 16384;
    run_frame(make_frame(3, 1000), 0, 40, y0);
    idle(20);
    run_frame(make_frame(3, 1000), 0, 0, y0);
    check("post_reset_impulse", y0, 500);
    run_frame(make_frame(2, 0), 0, 0, y0);
    check("post_reset_impulse2", y0, 1000);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
